// File: rtl/chest_buf_ctrl.sv
// Channel-estimate buffer: collects one bank of NSC per-subcarrier estimates and
// pairs each received data sample with its stored estimate for the equalizer.
module chest_buf_ctrl #(
    parameter int DW  = 16,
    parameter int NSC = 12
) (
    input  logic            i_clk_eq,
    input  logic            i_rst,
    input  logic [DW-1:0]   i_est_re,
    input  logic [DW-1:0]   i_est_im,
    input  logic [3:0]      i_indx,
    input  logic [NSC-1:0]  i_est_done,
    input  logic [2:0]      i_symbol_num,
    input  logic            i_data_valid,
    input  logic [DW-1:0]   i_data_re,
    input  logic [DW-1:0]   i_data_im,
    output logic [DW-1:0]   o_h_re,
    output logic [DW-1:0]   o_h_im,
    output logic [DW-1:0]   o_y_re,
    output logic [DW-1:0]   o_y_im,
    output logic [3:0]      o_sc_idx,
    output logic            o_eq_valid,
    output logic            o_sym_done,
    output logic            o_est_ready,
    output logic            o_err
);

    typedef enum logic [1:0] {IDLE, FILL, READY} state_t;

    localparam logic [3:0]     SC_LAST    = 4'(NSC - 1);
    localparam logic [NSC-1:0] MASK_FIRST = NSC'(1);
    localparam logic [2:0]     PILOT_SYM  = 3'b100;

    state_t         state;
    logic [DW-1:0]  rf_re [NSC];
    logic [DW-1:0]  rf_im [NSC];
    logic [NSC-1:0] mask;
    logic [NSC-1:0] exp_strobe;
    logic [NSC-1:0] mask_nxt;
    logic [3:0]     sc_cnt;
    logic           wr_ok;
    logic           bad_strobe;
    logic           data_req;
    logic           rf_wr;

    // A strobe is accepted only if it equals the one-hot decode of i_indx;
    // an out-of-range index decodes to zero and can never match a non-zero strobe.
    always_comb begin
        exp_strobe = '0;
        for (int unsigned i = 0; i < NSC; i++) begin
            if (i_indx == 4'(i)) exp_strobe[i] = 1'b1;
        end
        wr_ok      = (i_est_done != '0) && (i_est_done == exp_strobe);
        bad_strobe = (i_est_done != '0) && !wr_ok;
        mask_nxt   = mask | exp_strobe;
        data_req   = i_data_valid && (i_symbol_num != PILOT_SYM);
        rf_wr      = wr_ok && !i_rst && !((state == IDLE) && (i_indx != 4'd0));
    end

    // Register file is intentionally left out of reset; the mask gates its use.
    always_ff @(posedge i_clk_eq) begin
        if (rf_wr) begin
            rf_re[i_indx] <= i_est_re;
            rf_im[i_indx] <= i_est_im;
        end
    end

    always_ff @(posedge i_clk_eq) begin
        if (i_rst) begin
            state       <= IDLE;
            mask        <= '0;
            sc_cnt      <= '0;
            o_h_re      <= '0;
            o_h_im      <= '0;
            o_y_re      <= '0;
            o_y_im      <= '0;
            o_sc_idx    <= '0;
            o_eq_valid  <= 1'b0;
            o_sym_done  <= 1'b0;
            o_est_ready <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            o_eq_valid <= 1'b0;
            o_sym_done <= 1'b0;
            o_err      <= bad_strobe;

            // Read uses the pre-write entry even when a new bank starts this cycle.
            if (data_req) begin
                if (state == READY) begin
                    o_eq_valid <= 1'b1;
                    o_y_re     <= i_data_re;
                    o_y_im     <= i_data_im;
                    o_h_re     <= rf_re[sc_cnt];
                    o_h_im     <= rf_im[sc_cnt];
                    o_sc_idx   <= sc_cnt;
                    o_sym_done <= (sc_cnt == SC_LAST);
                    sc_cnt     <= (sc_cnt == SC_LAST) ? 4'd0 : sc_cnt + 4'd1;
                end else begin
                    o_err <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (wr_ok) begin
                        if (i_indx == 4'd0) begin
                            state  <= FILL;
                            mask   <= MASK_FIRST;
                            sc_cnt <= '0;
                        end else begin
                            o_err <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (wr_ok) begin
                        mask <= mask_nxt;
                        if (mask_nxt == '1) begin
                            state       <= READY;
                            o_est_ready <= 1'b1;
                        end
                    end
                end
                READY: begin
                    if (wr_ok) begin
                        if (i_indx == 4'd0) begin
                            state       <= FILL;
                            o_est_ready <= 1'b0;
                            mask        <= MASK_FIRST;
                            sc_cnt      <= '0;
                        end else begin
                            mask <= mask_nxt;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/chest_buf_ctrl.md
CHEST_BUF_CTRL -- requirements
Module: chest_buf_ctrl

Interface
REQ-001 Parameter DW, default 16: width of each real or imaginary component.
REQ-002 Parameter NSC, default 12: subcarriers per symbol.
REQ-003 Port i_clk_eq, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port i_rst, input, 1: reset, synchronous, active-high.
REQ-005 Port i_est_re / i_est_im, input, DW each: channel estimate for the subcarrier named by i_indx.
REQ-006 Port i_indx, input, 4: subcarrier index of the current estimate, 0..11.
REQ-007 Port i_est_done, input, NSC: one-hot write strobe from the estimation controller.
REQ-008 Port i_symbol_num, input, 3: current symbol number; 3'b100 is the pilot symbol.
REQ-009 Port i_data_valid, input, 1: received data subcarrier sample is present.
REQ-010 Port i_data_re / i_data_im, input, DW each: received sample, arriving in subcarrier order 0..11.
REQ-011 Port o_h_re / o_h_im, output, DW each: stored estimate paired with the output sample.
REQ-012 Port o_y_re / o_y_im, output, DW each: registered copy of the received sample.
REQ-013 Port o_sc_idx, output, 4: subcarrier index of the output pair.
REQ-014 Port o_eq_valid, output, 1: the output pair is valid.
REQ-015 Port o_sym_done, output, 1: one-cycle pulse with the pair for subcarrier 11.
REQ-016 Port o_est_ready, output, 1: all 12 estimates of the current bank are stored.
REQ-017 Port o_err, output, 1: one-cycle pulse on a protocol error.

Function
REQ-018 Storage is an NSC-entry register file for {re,im} plus an NSC-bit written mask.
REQ-019 State machine states: IDLE, FILL, READY.
REQ-020 Valid estimate write condition:
- i_est_done is exactly one-hot;
- its set bit position equals i_indx;
- i_indx < NSC.
REQ-021 A valid write stores i_est_re/i_est_im at entry i_indx and sets mask[i_indx].
REQ-022 i_est_done non-zero but not a valid write: no write; o_err pulses the next cycle.
REQ-023 IDLE -> FILL on a valid write with i_indx==0; mask is cleared to 1 at bit 0 only.
REQ-024 In IDLE, a valid write with i_indx!=0 is discarded, and o_err pulses.
REQ-025 FILL -> READY on the cycle the mask becomes all-ones.
- o_est_ready rises the same cycle as the state change to READY.
REQ-026 READY -> FILL on a valid write with i_indx==0 (new slot).
- o_est_ready drops the same cycle; the mask restarts at bit 0.
REQ-027 In FILL, rewriting an entry whose mask bit is already set overwrites the value; no error.
REQ-028 Data path, when i_data_valid=1 and i_symbol_num!=3'b100 in READY:
- one cycle later, o_eq_valid=1;
- o_y = the input sample; o_h = entry[sc_cnt]; o_sc_idx = sc_cnt.
REQ-029 sc_cnt (4 bits) increments per accepted sample and wraps 11 -> 0.
- o_sym_done pulses with the pair for sc_cnt=11.
REQ-030 i_data_valid with i_symbol_num==3'b100: sample ignored, sc_cnt unchanged, no error.
REQ-031 i_data_valid outside READY with i_symbol_num!=3'b100:
- sample dropped, sc_cnt unchanged;
- o_err pulses; o_eq_valid stays 0.
REQ-032 sc_cnt resets to 0 on every FILL entry.
REQ-033 Simultaneous READY->FILL write and data sample:
- the sample is served with the pre-write entry value (read-before-write);
- sc_cnt resets the following cycle.
REQ-034 Latency: input sample to o_eq_valid is exactly 1 cycle.
- Throughput: one sample per cycle, no backpressure.
REQ-035 When o_eq_valid=0, o_h, o_y and o_sc_idx hold their last values.

Reset
REQ-036 i_rst=1 at a clock edge sets:
- state IDLE, mask 0, sc_cnt 0;
- all outputs 0.
REQ-037 The register file contents are not reset.
- Because the mask is cleared, the block does not reach READY until a full fill completes.
REQ-038 Reset asserted mid-FILL or mid-symbol abandons the partial bank.
- No o_sym_done and no o_err is issued for the aborted operation.

Verification
REQ-039 Fill: writes of indices 0..11 with est_re=idx*3 on consecutive cycles -> o_est_ready=1 the cycle after idx 11 is written, o_err never asserted.
REQ-040 Stream: READY, symbol_num=1, 12 consecutive samples y_re=100+k -> o_eq_valid for 12 cycles, o_h_re=3k, o_sc_idx=k, o_sym_done only at k=11.
REQ-041 Pilot/no-estimate: samples with symbol_num=4 -> no output, no error; samples in IDLE with symbol_num=2 -> o_err pulses each, o_eq_valid=0.
REQ-042 Bad strobe: i_est_done=12'h003, then i_est_done=12'h004 with i_indx=5 -> no mask change, two o_err pulses.
REQ-043 Collision: in READY, a new idx-0 write (est_re=77) coincides with a sample at sc_cnt=0 -> output o_h_re equals the old value; next cycle o_est_ready=0, sc_cnt=0.
REQ-044 Reset mid-FILL after 6 writes -> all outputs 0; a following 12-write fill is needed before o_est_ready=1.
